a23_mem_master: RTL and testbench
=================================

// Module: a23_mem_master
// PURPOSE
//  Bus initiator for the a23 unified memory (code/garbler/evaluator/out/stack regions, 0x00..0x04 in addr[31:24]).
//  Converts byte/halfword/word load-store requests into legal memory cycles: byte enables 1111 or one-hot only, data in lane [7:0].
//  Halfword stores are split into two byte cycles. Loads are zero- or sign-extended.
//  Stores to read-only regions are blocked. Sits between the core load/store stage and the memory.
// PARAMETERS
//  RO_REGION_LO  8'h01  lowest read-only region id (garbler inputs)
//  RO_REGION_HI  8'h02  highest read-only region id (evaluator inputs)
//  TOP_REGION    8'h04  highest valid region id; ids above are unmapped
// PORTS
//  i_clk            in   1   clock
//  i_rst            in   1   reset; asynchronous, active-high
//  i_req_valid      in   1   request valid
//  o_req_ready      out  1   request accepted when valid&ready
//  i_req_write      in   1   1=store, 0=load
//  i_req_size       in   2   00 byte, 01 halfword, 10 word, 11 illegal
//  i_req_signed     in   1   sign-extend a byte/halfword load
//  i_req_addr       in   32  byte address
//  i_req_wdata      in   32  store data, right-aligned
//  o_rsp_valid      out  1   one-cycle completion pulse; no backpressure
//  o_rsp_rdata      out  32  load data (0 for stores and errors)
//  o_rsp_err        out  1   qualifies o_rsp_valid; access not performed
//  o_m_address      out  32  memory address
//  o_m_write        out  32  memory write data
//  o_m_write_en     out  1   memory write strobe
//  o_m_byte_enable  out  4   memory byte enable
//  i_m_read         in   32  memory read data (combinational from o_m_address)
// BEHAVIOUR
//  - States: IDLE, ACC0, ACC1, RESP. o_req_ready = (state==IDLE); all request fields are registered on accept.
//  - Reset: state IDLE, o_req_ready=1. o_rsp_valid, o_rsp_rdata, o_rsp_err, o_m_* all 0.
//  - IDLE: on valid&ready -> ACC0. If the request is illegal -> RESP with err=1 and no bus activity.
//    Illegal = size 11; region > TOP_REGION; or store with RO_REGION_LO <= region <= RO_REGION_HI.
//  - ACC0: o_m_address = addr.
//    Load: we=0, be=0. Capture i_m_read this cycle.
//      Byte -> [7:0]; half -> [15:0]. Extend with bit 7/15 if signed, else zero. Word unchanged. -> RESP.
//    Store word: we=1, be=1111, write=wdata -> RESP.
//    Store byte: we=1, be=0001, write={24'b0,wdata[7:0]} -> RESP.
//    Store half: we=1, be=0001, write[7:0]=wdata[7:0] -> ACC1.
//  - ACC1 (half store only): address=addr, we=1, be=0010, write[7:0]=wdata[15:8] -> RESP.
//  - RESP: o_rsp_valid=1 for exactly one cycle, with rdata/err held valid that cycle; then -> IDLE.
//    o_rsp_rdata/o_rsp_err return to 0 afterwards.
//  - Latency, accept cycle T: load/byte/word store -> rsp at T+2. Half store -> rsp at T+3. Illegal -> rsp at T+1.
//  - Outside ACC0/ACC1, o_m_* are 0. The address is never incremented; the memory applies lane offsets.
//  - Unaligned addresses are passed through unchanged when ALIGN_CHECK is off; the memory handles byte-granular addressing.
//  - Back-to-back: the earliest next accept is the cycle after RESP.
//  - Reset mid-operation aborts with no response. A partially written halfword is not recovered; the memory reset reinitialises it.
// CONFIGURATION
//  A23_MEM_MASTER_ALIGN_CHECK_EN
//   defined:   a halfword with addr[0]!=0 or a word with addr[1:0]!=0 is illegal (err=1, no bus cycle, rsp at T+1).
//   undefined: no alignment check; unaligned accesses are issued as normal.
// TESTING
//  1 Word store 0xDEADBEEF @0x03000008 -> one cycle: we=1, be=1111; rsp at T+2, err=0; a later load returns 0xDEADBEEF.
//  2 Half store 0xA5C3 @0x04000010 -> cycle1 be=0001, write[7:0]=C3; cycle2 be=0010, write[7:0]=A5.
//    rsp at T+3; signed half load returns 0xFFFFA5C3.
//  3 Byte load @0x01000000, memory data 0x00000080 -> signed: 0xFFFFFF80; unsigned: 0x00000080; we stays 0.
//  4 Store to 0x02000004, and load from 0x05000000 -> err=1 at T+1, o_m_write_en never asserted.
//  5 Word store @0x00000002 -> with _EN defined: err=1, no write. Without it: be=1111 @0x00000002, err=0.
//  6 Assert i_rst during the ACC1 cycle of a half store -> all outputs 0 next edge, no rsp_valid, o_req_ready=1.

Source files
------------

// File: rtl/a23_mem_master.sv
// ============================================================================
//  Module      : a23_mem_master
//  Description : Bus initiator for the a23 unified memory. Turns byte /
//                halfword / word load-store requests into legal memory
//                cycles (byte enables 1111 or one-hot, data in lane [7:0]),
//                splits halfword stores into two byte cycles, zero- or
//                sign-extends loads and blocks stores to read-only regions.
//  Ports       : i_clk, i_rst (async, active-high)
//                request : i_req_valid/o_req_ready, i_req_write, i_req_size,
//                          i_req_signed, i_req_addr, i_req_wdata
//                response: o_rsp_valid, o_rsp_rdata, o_rsp_err
//                memory  : o_m_address, o_m_write, o_m_write_en,
//                          o_m_byte_enable, i_m_read
//  Config      : `define A23_MEM_MASTER_ALIGN_CHECK_EN to reject misaligned
//                halfword/word accesses with an error response.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module a23_mem_master #(
    parameter logic [7:0] RO_REGION_LO = 8'h01,
    parameter logic [7:0] RO_REGION_HI = 8'h02,
    parameter logic [7:0] TOP_REGION   = 8'h04
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_m_address,
    output logic [31:0] o_m_write,
    output logic        o_m_write_en,
    output logic [3:0]  o_m_byte_enable,
    input  logic [31:0] i_m_read
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t      state_q;
    logic        ready_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [7:0]  wdata_hi_q;     // upper byte of a halfword store, sent in ACC1
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] m_address_q;
    logic [31:0] m_write_q;
    logic        m_write_en_q;
    logic [3:0]  m_byte_enable_q;

    logic [7:0]  w_region;
    logic        w_misaligned;
    logic        w_illegal;
    logic [31:0] w_load_data;
    logic [3:0]  w_first_be;
    logic [31:0] w_first_wdata;

    assign w_region = i_req_addr[31:24];

`ifdef A23_MEM_MASTER_ALIGN_CHECK_EN
    assign w_misaligned = ((i_req_size == SZ_HALF) && i_req_addr[0]) ||
                          ((i_req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_illegal = (i_req_size == SZ_ILL) ||
                       (w_region > TOP_REGION) ||
                       (i_req_write && (w_region >= RO_REGION_LO) &&
                        (w_region <= RO_REGION_HI)) ||
                       w_misaligned;

    // First bus cycle: word stores use all lanes, byte/half stores lane 0,
    // loads drive no enables.
    always_comb begin
        w_first_be    = 4'b0000;
        w_first_wdata = 32'h0;
        if (i_req_write) begin
            if (i_req_size == SZ_WORD) begin
                w_first_be    = 4'b1111;
                w_first_wdata = i_req_wdata;
            end else begin
                w_first_be    = 4'b0001;
                w_first_wdata = {24'h0, i_req_wdata[7:0]};
            end
        end
    end

    // Load data is combinational from the address driven during ACC0.
    always_comb begin
        w_load_data = i_m_read;
        case (size_q)
            SZ_BYTE: w_load_data = {{24{signed_q & i_m_read[7]}},  i_m_read[7:0]};
            SZ_HALF: w_load_data = {{16{signed_q & i_m_read[15]}}, i_m_read[15:0]};
            default: w_load_data = i_m_read;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= IDLE;
            ready_q         <= 1'b1;
            write_q         <= 1'b0;
            size_q          <= 2'b00;
            signed_q        <= 1'b0;
            addr_q          <= 32'h0;
            wdata_hi_q      <= 8'h0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= 32'h0;
            rsp_err_q       <= 1'b0;
            m_address_q     <= 32'h0;
            m_write_q       <= 32'h0;
            m_write_en_q    <= 1'b0;
            m_byte_enable_q <= 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid && ready_q) begin
                        ready_q    <= 1'b0;
                        write_q    <= i_req_write;
                        size_q     <= i_req_size;
                        signed_q   <= i_req_signed;
                        addr_q     <= i_req_addr;
                        wdata_hi_q <= i_req_wdata[15:8];
                        if (w_illegal) begin
                            // Error responses skip the bus entirely.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q         <= ACC0;
                            m_address_q     <= i_req_addr;
                            m_write_en_q    <= i_req_write;
                            m_byte_enable_q <= w_first_be;
                            m_write_q       <= w_first_wdata;
                        end
                    end
                end

                ACC0: begin
                    if (write_q && (size_q == SZ_HALF)) begin
                        // Same address; the memory places lane 1 at addr+1.
                        state_q         <= ACC1;
                        m_byte_enable_q <= 4'b0010;
                        m_write_q       <= {24'h0, wdata_hi_q};
                    end else begin
                        state_q         <= RESP;
                        rsp_valid_q     <= 1'b1;
                        rsp_err_q       <= 1'b0;
                        rsp_rdata_q     <= write_q ? 32'h0 : w_load_data;
                        m_address_q     <= 32'h0;
                        m_write_q       <= 32'h0;
                        m_write_en_q    <= 1'b0;
                        m_byte_enable_q <= 4'b0000;
                    end
                end

                ACC1: begin
                    state_q         <= RESP;
                    rsp_valid_q     <= 1'b1;
                    rsp_err_q       <= 1'b0;
                    rsp_rdata_q     <= 32'h0;
                    m_address_q     <= 32'h0;
                    m_write_q       <= 32'h0;
                    m_write_en_q    <= 1'b0;
                    m_byte_enable_q <= 4'b0000;
                end

                RESP: begin
                    state_q     <= IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready     = ready_q;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_rdata     = rsp_rdata_q;
    assign o_rsp_err       = rsp_err_q;
    assign o_m_address     = m_address_q;
    assign o_m_write       = m_write_q;
    assign o_m_write_en    = m_write_en_q;
    assign o_m_byte_enable = m_byte_enable_q;

endmodule

`default_nettype wire

// File: tb/tb_a23_mem_master.sv
// ============================================================================
//  Module      : tb_a23_mem_master
//  Description : Scoreboard bench for a23_mem_master. A byte-array memory
//                model sits on the bus; a byte-level reference memory
//                predicts every response, which a monitor compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_a23_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] m_address;
    logic [31:0] m_write;
    logic        m_write_en;
    logic [3:0]  m_byte_enable;
    logic [31:0] m_read;

    always #5 clk = ~clk;

    a23_mem_master dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_write     (req_write),
        .i_req_size      (req_size),
        .i_req_signed    (req_signed),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_rdata     (rsp_rdata),
        .o_rsp_err       (rsp_err),
        .o_m_address     (m_address),
        .o_m_write       (m_write),
        .o_m_write_en    (m_write_en),
        .o_m_byte_enable (m_byte_enable),
        .i_m_read        (m_read)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // ---------------- bus memory (byte addressed, lane offsets applied) ----
    logic [7:0]  bmem [0:2047];
    logic [7:0]  refm [0:2047];
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr = 32'h0;
    logic [7:0]  poke_data = 8'h0;

    function automatic int idx(input logic [31:0] a);
        return int'({a[26:24], a[7:0]});
    endfunction

    always_comb begin
        m_read = {bmem[idx(m_address + 32'd3)], bmem[idx(m_address + 32'd2)],
                  bmem[idx(m_address + 32'd1)], bmem[idx(m_address)]};
    end

    always @(posedge clk) begin
        if (poke_en) begin
            bmem[idx(poke_addr)] <= poke_data;
        end else if (m_write_en) begin
            case (m_byte_enable)
                4'b1111: begin
                    bmem[idx(m_address)]          <= m_write[7:0];
                    bmem[idx(m_address + 32'd1)] <= m_write[15:8];
                    bmem[idx(m_address + 32'd2)] <= m_write[23:16];
                    bmem[idx(m_address + 32'd3)] <= m_write[31:24];
                end
                4'b0001: bmem[idx(m_address)]          <= m_write[7:0];
                4'b0010: bmem[idx(m_address + 32'd1)] <= m_write[7:0];
                4'b0100: bmem[idx(m_address + 32'd2)] <= m_write[7:0];
                4'b1000: bmem[idx(m_address + 32'd3)] <= m_write[7:0];
                default: ;
            endcase
        end
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        refm[idx(a)] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // ---------------- reference model + scoreboard -------------------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] addr;
        int          t;
    } exp_t;

    exp_t q[$];

    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   region;
        logic ill;
        logic [7:0] b0, b1, b2, b3;
        region = int'(a[31:24]);
        ill = (sz == 2'b11) || (region > 4) || (wr && region >= 1 && region <= 2);
`ifdef A23_MEM_MASTER_ALIGN_CHECK_EN
        if (sz == 2'b01 && a[0] != 1'b0) ill = 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) ill = 1'b1;
`endif
        e.addr = a; e.t = 0; e.be0 = 4'h0; e.be1 = 4'h0; e.rdata = 32'h0;
        e.err = ill; e.nwr = 0; e.lat = 2;
        if (ill) begin
            e.lat = 1;
        end else if (wr) begin
            refm[idx(a)] = wd[7:0];
            if (sz >= 2'b01) refm[idx(a + 32'd1)] = wd[15:8];
            if (sz == 2'b10) begin
                refm[idx(a + 32'd2)] = wd[23:16];
                refm[idx(a + 32'd3)] = wd[31:24];
            end
            e.nwr = (sz == 2'b01) ? 2 : 1;
            e.lat = (sz == 2'b01) ? 3 : 2;
            e.be0 = (sz == 2'b10) ? 4'hF : 4'h1;
            e.be1 = 4'h2;
        end else begin
            b0 = refm[idx(a)];
            b1 = refm[idx(a + 32'd1)];
            b2 = refm[idx(a + 32'd2)];
            b3 = refm[idx(a + 32'd3)];
            if (sz == 2'b00)
                e.rdata = (sg && b0[7]) ? {24'hFFFFFF, b0} : {24'h0, b0};
            else if (sz == 2'b01)
                e.rdata = (sg && b1[7]) ? {16'hFFFF, b1, b0} : {16'h0, b1, b0};
            else
                e.rdata = {b3, b2, b1, b0};
        end
        return e;
    endfunction

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   n;
        e = model(wr, sz, sg, a, wd);
        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: ready stayed 0, expected 1");
            req_valid = 1'b0;
            return;
        end
        e.t = cyc;
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // ---------------- monitor ----------------------------------------------
    int         wcnt = 0;
    logic [3:0] be_s0 = 4'h0, be_s1 = 4'h0;
    logic       addr_bad = 1'b0, hi_bad = 1'b0;
    int         rsp_seen = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            wcnt = 0; addr_bad = 1'b0; hi_bad = 1'b0;
        end else begin
            if (m_write_en) begin
                if (q.size() > 0 && m_address != q[0].addr) addr_bad = 1'b1;
                if (m_byte_enable != 4'hF && m_write[31:8] != 24'h0) hi_bad = 1'b1;
                if (wcnt == 0) be_s0 = m_byte_enable;
                else if (wcnt == 1) be_s1 = m_byte_enable;
                wcnt++;
            end
            if (rsp_valid) begin
                rsp_seen++;
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with empty scoreboard, expected 0");
                end else begin
                    e = q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    chk("rsp_latency", cyc - e.t, e.lat);
                    chk("write_cycles", wcnt, e.nwr);
                    if (e.nwr > 0) chk("be_cycle0", {28'h0, be_s0}, {28'h0, e.be0});
                    if (e.nwr > 1) chk("be_cycle1", {28'h0, be_s1}, {28'h0, e.be1});
                    chk("write_addr_ok", {31'h0, addr_bad}, 32'h0);
                    chk("narrow_lane_ok", {31'h0, hi_bad}, 32'h0);
                    chk("bus_idle_in_rsp", {m_address[30:0] | m_write[30:0], m_address[31] | m_write_en | (|m_byte_enable) | m_write[31]}, 32'h0);
                end
                wcnt = 0; addr_bad = 1'b0; hi_bad = 1'b0;
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int n;
        // Reset asserted while both memories get identical random contents.
        for (int i = 0; i < 2048; i++) begin
            logic [31:0] ia;
            ia = {5'h0, 3'(i >> 8), 16'h0, 8'(i)};
            poke(ia, 8'($urandom));
        end
        chk("reset_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_maddr", m_address, 32'h0);
        chk("reset_mwrite", m_write, 32'h0);
        chk("reset_mctl", {27'h0, m_write_en, m_byte_enable}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load back.
        issue(1'b1, 2'b10, 1'b0, 32'h0300_0008, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h0300_0008, 32'h0);
        // Split halfword store, signed and unsigned load back.
        issue(1'b1, 2'b01, 1'b0, 32'h0400_0010, 32'h0000_A5C3);
        issue(1'b0, 2'b01, 1'b1, 32'h0400_0010, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h0400_0010, 32'h0);
        // Byte load extension from a read-only region.
        poke(32'h0100_0000, 8'h80);
        issue(1'b0, 2'b00, 1'b1, 32'h0100_0000, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h0100_0000, 32'h0);
        // Blocked store, unmapped region, illegal size.
        issue(1'b1, 2'b10, 1'b0, 32'h0200_0004, 32'h1234_5678);
        issue(1'b0, 2'b10, 1'b0, 32'h0500_0000, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        // Unaligned word store and reload.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0002, 32'h1357_9BDF);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);

        // Randomised traffic over a small address window to force reuse.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] rg, off;
            rg  = 8'($urandom_range(0, 6));
            off = 8'($urandom_range(0, 15));
            issue(1'($urandom), 2'($urandom), 1'($urandom), {rg, 16'h0, off}, $urandom);
        end

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", q.size(), 0);

        // Reset during ACC1 of a halfword store aborts with no response.
        issue(1'b1, 2'b01, 1'b0, 32'h0400_0020, 32'h0000_7E81);
        @(negedge clk);
        @(negedge clk);
        chk("acc1_ctl", {27'h0, m_write_en, m_byte_enable}, 32'h12);
        rsp_seen = 0;
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_bus", {m_write[31:1] | m_address[31:1], |{m_write[0], m_address[0], m_write_en, m_byte_enable, rsp_valid, rsp_err, rsp_rdata}}, 32'h0);
        @(negedge clk);
        q.delete();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("no_rsp_after_abort", rsp_seen, 0);
        poke(32'h0400_0020, 8'h11);
        poke(32'h0400_0021, 8'h22);
        issue(1'b0, 2'b01, 1'b0, 32'h0400_0020, 32'h0);
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("final_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
